codec_i2c_scheduler: RTL and testbench



---
 rtl/codec_i2c_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_codec_i2c_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_scheduler.sv
// Round-robin arbiter sharing one I2C_Controller (audio codec) between register-write requesters.
// Optional per-register shadow of ACKed writes is enabled by defining CODEC_SHADOW_EN.
module codec_i2c_scheduler #(
  parameter int         NUM_REQ     = 3,
  parameter logic [7:0] SLAVE_ADDR  = 8'h34,
  parameter int         CLK_DIV     = 1250,
  parameter int         MAX_RETRY   = 3,
  parameter int         HOLDOFF_CYC = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  output logic                   ctrl_clk,
  output logic [23:0]            i2c_data,
  output logic                   i2c_go,
  input  logic                   i2c_end,
  input  logic                   i2c_ack,
`ifdef CODEC_SHADOW_EN
  input  logic [3:0]             shadow_addr,
  output logic [8:0]             shadow_data,
`endif
  output logic                   i2c_rst_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int HLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_END,
    S_CHECK,
    S_HOLD
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick_r;
  logic               end_meta, end_s;
  logic               ack_meta, ack_s;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt;
  logic [15:0]        cap_data;
  logic [RTY_W-1:0]   retry;
  logic               retry_pend;
  logic               result_err;
  logic               ack_r;
  logic [HLD_W-1:0]   hold_cnt;

  logic [PTR_W-1:0]   grant_idx;
  logic [15:0]        grant_data;
  int                 best_d;

  assign i2c_rst_n = ~reset;

  // ctrl_clk is a plain register; tick_r marks the system cycle in which it rose.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      ctrl_clk <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
        div_cnt  <= '0;
        ctrl_clk <= ~ctrl_clk;
        tick_r   <= ~ctrl_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      end_meta <= 1'b0;
      end_s    <= 1'b0;
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      end_meta <= i2c_end;
      end_s    <= end_meta;
      ack_meta <= i2c_ack;
      ack_s    <= ack_meta;
    end
  end

  // Pick the pending requester closest after ptr in rotation order (ptr itself comes last).
  always_comb begin
    best_d     = NUM_REQ;
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (((i + 2*NUM_REQ - int'(ptr) - 1) % NUM_REQ) < best_d)) begin
        best_d     = (i + 2*NUM_REQ - int'(ptr) - 1) % NUM_REQ;
        grant_idx  = PTR_W'(i);
        grant_data = req_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      i2c_go     <= 1'b0;
      i2c_data   <= '0;
      cap_data   <= '0;
      gnt        <= '0;
      ptr        <= '0;
      retry      <= '0;
      retry_pend <= 1'b0;
      result_err <= 1'b0;
      ack_r      <= 1'b0;
      hold_cnt   <= '0;
      done       <= '0;
      err        <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt      <= grant_idx;
            cap_data <= grant_data;
            retry    <= '0;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tick_r) begin
            i2c_data <= {SLAVE_ADDR, cap_data};
            i2c_go   <= 1'b1;
            state    <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (end_s) begin
            ack_r <= ack_s;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          retry_pend <= 1'b0;
          result_err <= 1'b0;
          hold_cnt   <= '0;
          if (ack_r) begin
            if (retry < RTY_W'(MAX_RETRY)) begin
              retry      <= retry + 1'b1;
              retry_pend <= 1'b1;
            end else begin
              result_err <= 1'b1;
            end
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          // First tick releases GO, then HOLDOFF_CYC further ticks of idle bus.
          if (tick_r) begin
            if (i2c_go) begin
              i2c_go <= 1'b0;
            end else if (hold_cnt == HLD_W'(HOLDOFF_CYC - 1)) begin
              if (retry_pend) begin
                state <= S_ISSUE;
              end else begin
                done[gnt] <= 1'b1;
                err[gnt]  <= result_err;
                ptr       <= gnt;
                busy      <= 1'b0;
                state     <= S_IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CODEC_SHADOW_EN
  logic [8:0] shadow [0:9];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) shadow[i] <= '0;
    end else if (state == S_CHECK && !ack_r && i2c_data[15:9] <= 7'd9) begin
      shadow[i2c_data[12:9]] <= i2c_data[8:0];
    end
  end

  assign shadow_data = (shadow_addr <= 4'd9) ? shadow[shadow_addr] : 9'd0;
`endif

endmodule

// File: tb/tb_codec_i2c_scheduler.sv
// Randomized scoreboard bench for codec_i2c_scheduler with a behavioural I2C controller model.
// Expected GO transactions and done pulses are queued at stimulus time and checked by a monitor.
module tb_codec_i2c_scheduler;

  localparam int         NUM_REQ     = 3;
  localparam logic [7:0] SLV         = 8'h34;
  localparam int         CLK_DIV     = 4;
  localparam int         MAX_RETRY   = 3;
  localparam int         HOLDOFF_CYC = 4;

  typedef struct packed { logic retry; logic [23:0] data; } go_t;
  typedef struct packed { logic e; logic [7:0] idx; } done_t;

  logic                  CLOCK_50;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    done;
  logic [NUM_REQ-1:0]    err;
  logic                  busy;
  logic                  ctrl_clk;
  logic [23:0]           i2c_data;
  logic                  i2c_go;
  logic                  i2c_end;
  logic                  i2c_ack;
  logic                  i2c_rst_n;
`ifdef CODEC_SHADOW_EN
  logic [3:0]            shadow_addr;
  logic [8:0]            shadow_data;
`endif

  go_t   exp_go[$];
  done_t exp_done[$];
  logic  ack_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ptr_m = 0;

  codec_i2c_scheduler #(
    .NUM_REQ(NUM_REQ), .SLAVE_ADDR(SLV), .CLK_DIV(CLK_DIV),
    .MAX_RETRY(MAX_RETRY), .HOLDOFF_CYC(HOLDOFF_CYC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_data(req_data),
    .done(done), .err(err), .busy(busy), .ctrl_clk(ctrl_clk),
    .i2c_data(i2c_data), .i2c_go(i2c_go), .i2c_end(i2c_end), .i2c_ack(i2c_ack),
`ifdef CODEC_SHADOW_EN
    .shadow_addr(shadow_addr), .shadow_data(shadow_data),
`endif
    .i2c_rst_n(i2c_rst_n)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Next requester in rotation order strictly after p, wrapping around to p itself.
  function automatic int nextGrant(input logic [NUM_REQ-1:0] pending, input int p);
    for (int k = 1; k <= NUM_REQ; k++)
      if (pending[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  // Controller model: END stays low while GO is low; three ctrl_clk periods after GO it reports END with the queued ACK.
  int ctl_cnt = 0;
  always @(negedge ctrl_clk or posedge reset) begin
    if (reset) begin
      i2c_end = 1'b0;
      i2c_ack = 1'b0;
      ctl_cnt = 0;
    end else if (!i2c_go) begin
      i2c_end = 1'b0;
      ctl_cnt = 0;
    end else if (!i2c_end) begin
      ctl_cnt++;
      if (ctl_cnt == 3) begin
        i2c_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
        i2c_end = 1'b1;
      end
    end
  end

  // Monitor: every GO rising edge and every done pulse is matched against the scoreboard queues.
  logic go_prev = 1'b0, ck_prev = 1'b0, ck_prev2 = 1'b0, have_prev_go = 1'b0;
  int   gap = 0;
  go_t  g;
  done_t d;
  logic [NUM_REQ-1:0] oh;
  always @(negedge CLOCK_50) begin
    if (reset) begin
      go_prev = 1'b0; ck_prev = 1'b0; ck_prev2 = 1'b0; have_prev_go = 1'b0; gap = 0;
    end else begin
      if (i2c_go && !go_prev) begin
        if (exp_go.size() == 0) begin
          checkOutput("go_unexpected", 32'd1, 32'd0);
        end else begin
          g = exp_go.pop_front();
          checkOutput("go_data", {8'h0, i2c_data}, {8'h0, g.data});
          checkOutput("go_busy", {31'h0, busy}, 32'd1);
          checkOutput("go_after_tick", {29'h0, ck_prev2, ck_prev, ctrl_clk}, 32'd3);
          // Ctrl rising edges seen with GO low: the HOLDOFF_CYC counted ones plus the issuing edge.
          if (have_prev_go) begin
            if (g.retry) checkOutput("retry_gap", gap, HOLDOFF_CYC + 1);
            else checkOutput("holdoff_min", {31'h0, gap >= HOLDOFF_CYC + 1}, 32'd1);
          end
        end
        have_prev_go = 1'b1;
        gap = 0;
      end else if (!i2c_go && !go_prev && ctrl_clk && !ck_prev) begin
        gap++;
      end
      if (done != '0) begin
        if (exp_done.size() == 0) begin
          checkOutput("done_unexpected", {29'h0, done}, 32'd0);
        end else begin
          d = exp_done.pop_front();
          oh = '0;
          oh[d.idx] = 1'b1;
          checkOutput("done_vec", {29'h0, done}, {29'h0, oh});
          checkOutput("err_vec", {29'h0, err}, d.e ? {29'h0, oh} : 32'd0);
        end
      end
      go_prev = i2c_go; ck_prev2 = ck_prev; ck_prev = ctrl_clk;
    end
  end

  // Queue expected traffic for requesters in mask (nk = NACK count each, > MAX_RETRY means always NACK), then run it.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [16*NUM_REQ-1:0] data,
                               input logic [3*NUM_REQ-1:0] nk);
    logic [NUM_REQ-1:0] pending;
    int p, i, n, attempts, cnt, seen, cyc;
    pending = mask; p = ptr_m; cnt = 0;
    while (pending != '0) begin
      i = nextGrant(pending, p);
      n = int'(nk[3*i +: 3]);
      attempts = (n > MAX_RETRY) ? MAX_RETRY + 1 : n + 1;
      for (int a = 0; a < attempts; a++) begin
        exp_go.push_back('{retry: (a > 0), data: {SLV, data[16*i +: 16]}});
        ack_q.push_back(a < n);
      end
      exp_done.push_back('{e: (n > MAX_RETRY), idx: 8'(i)});
      pending[i] = 1'b0; p = i; cnt++;
    end
    ptr_m = p;
    @(negedge CLOCK_50);
    req_data = data;
    req = mask;
    seen = 0; cyc = 0;
    while (seen < cnt && cyc < 6000) begin
      @(negedge CLOCK_50);
      cyc++;
      for (int j = 0; j < NUM_REQ; j++)
        if (done[j]) begin req[j] = 1'b0; seen++; end
    end
    if (seen < cnt) checkOutput("done_timeout", seen, cnt);
    req = '0;
    @(negedge CLOCK_50);
    checkOutput("busy_after", {31'h0, busy}, 32'd0);
    checkOutput("go_q_drained", exp_go.size(), 0);
    checkOutput("done_q_drained", exp_done.size(), 0);
  endtask

  initial begin
    int p, seen, cyc, n;
    logic [16*NUM_REQ-1:0] rdata;
    logic [3*NUM_REQ-1:0]  rnk;
    reset = 1'b1;
    req = 3'b111;
    req_data = {16'h0A11, 16'h0C22, 16'h0E33};
    `ifdef CODEC_SHADOW_EN
    shadow_addr = 4'd0;
    `endif
    #55;
    checkOutput("rst_done", {29'h0, done}, 32'd0);
    checkOutput("rst_err", {29'h0, err}, 32'd0);
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_ctrl_clk", {31'h0, ctrl_clk}, 32'd0);
    checkOutput("rst_go", {31'h0, i2c_go}, 32'd0);
    checkOutput("rst_data", {8'h0, i2c_data}, 32'd0);
    checkOutput("rst_rst_n", {31'h0, i2c_rst_n}, 32'd0);

    // All requests held from reset: rotation from ptr 0 with every requester always pending.
    p = 0;
    for (int t = 0; t < 4; t++) begin
      p = nextGrant(3'b111, p);
      exp_go.push_back('{retry: 1'b0, data: {SLV, req_data[16*p +: 16]}});
      ack_q.push_back(1'b0);
      exp_done.push_back('{e: 1'b0, idx: 8'(p)});
    end
    ptr_m = p;
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    checkOutput("rst_n_release", {31'h0, i2c_rst_n}, 32'd1);
    seen = 0; cyc = 0;
    while (seen < 4 && cyc < 6000) begin
      @(negedge CLOCK_50);
      cyc++;
      if (done != '0) seen++;
    end
    req = '0;
    if (seen < 4) checkOutput("rr_timeout", seen, 4);
    @(negedge CLOCK_50);
    checkOutput("rr_busy_after", {31'h0, busy}, 32'd0);

    applyStimulus(3'b001, {32'h0, 16'h0C00}, 9'd0);
    applyStimulus(3'b010, {16'h0, 16'h1234, 16'h0}, {3'd0, 3'd2, 3'd0});
    applyStimulus(3'b011, {16'h0, 16'h0C3C, 16'h0A5A}, {3'd0, 3'd0, 3'd4});

`ifdef CODEC_SHADOW_EN
    applyStimulus(3'b001, {32'h0, 16'h0E41}, 9'd0);
    applyStimulus(3'b001, {32'h0, 16'h08AA}, 9'd0);
    applyStimulus(3'b001, {32'h0, 16'h0955}, {3'd0, 3'd0, 3'd4});
    shadow_addr = 4'd7; #1;
    checkOutput("shadow_reg7", {23'h0, shadow_data}, 32'h041);
    shadow_addr = 4'd4; #1;
    checkOutput("shadow_reg4_kept", {23'h0, shadow_data}, 32'h0AA);
    shadow_addr = 4'd12; #1;
    checkOutput("shadow_oob", {23'h0, shadow_data}, 32'h0);
`endif

    // Reset while the controller is mid-transfer: the attempt is abandoned without a done pulse.
    @(negedge CLOCK_50);
    req_data = {$urandom, $urandom};
    exp_go.push_back('{retry: 1'b0, data: {SLV, req_data[15:0]}});
    ack_q.push_back(1'b0);
    req = 3'b001;
    cyc = 0;
    while (!i2c_go && cyc < 500) begin @(negedge CLOCK_50); cyc++; end
    checkOutput("go_before_reset", {31'h0, i2c_go}, 32'd1);
    repeat (2) @(negedge CLOCK_50);
    req = '0;
    reset = 1'b1;
    #1;
    checkOutput("midrst_go", {31'h0, i2c_go}, 32'd0);
    checkOutput("midrst_busy", {31'h0, busy}, 32'd0);
    checkOutput("midrst_rst_n", {31'h0, i2c_rst_n}, 32'd0);
    ack_q.delete();
    exp_go.delete();
    ptr_m = 0;
    repeat (4) @(negedge CLOCK_50);
    checkOutput("midrst_no_done", {29'h0, done}, 32'd0);
    reset = 1'b0;
    applyStimulus(3'b100, {16'h1E5A, 16'h0111, 16'h0222}, 9'd0);

    for (int b = 0; b < 6; b++) begin
      rdata = {$urandom, $urandom};
      for (int i = 0; i < NUM_REQ; i++) begin
        n = $urandom_range(0, 9);
        rnk[3*i +: 3] = (n < 5) ? 3'd0 : (n < 7) ? 3'd1 : (n < 9) ? 3'd2 : 3'd4;
      end
      applyStimulus(3'($urandom_range(1, 7)), rdata, rnk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
